// File: rtl/data_bus_responder_if.sv
// Data-memory bus between the single-cycle core and its responder, plus the
// GPIO and TX drain side-band signals that travel with it.
interface data_bus_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic [31:0] gpio_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    // Core side: issues requests and drains the TX FIFO.
    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata, tx_ready,
        input  mem_rdata, bus_err, gpio_out, tx_valid, tx_data
    );

    // Responder side: answers requests and owns the MMIO state.
    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata, tx_ready,
        output mem_rdata, bus_err, gpio_out, tx_valid, tx_data
    );
endinterface

// File: rtl/data_bus_responder.sv
// Slave end of the core's data bus: word RAM, a 64-bit cycle counter with a
// read-snapshot high half, a GPIO register and a byte TX FIFO.
// Reads are combinational in the request cycle; writes commit on the edge.
module data_bus_responder #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    data_bus_responder_if.slave bus
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [32:0]      RAM_BYTES  = 33'(RAM_WORDS) << 2;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    localparam logic [4:0] OFF_CYCLE_LO = 5'h00;
    localparam logic [4:0] OFF_CYCLE_HI = 5'h04;
    localparam logic [4:0] OFF_GPIO     = 5'h08;
    localparam logic [4:0] OFF_TX_DATA  = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;

    logic [31:0]      ram [RAM_WORDS];
    logic [7:0]       fifoMem [FIFO_DEPTH];

    logic [63:0]      cycleCount_q, cycleCount_d;
    logic [31:0]      cycleShadow_q, cycleShadow_d;
    logic [31:0]      gpio_q, gpio_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] fifoCount_q, fifoCount_d;
    logic             ovf_q, ovf_d;

    logic             aligned, ramOk, mmioOk, isRead, isWrite;
    logic [4:0]       regOff;
    logic [RAM_AW-1:0] ramIdx;
    logic             ramWe, gpioWe, pushReq, pushOk, pop, overflow;
    logic             statusClear, shadowLatch;
    logic             fifoFull, fifoEmpty;
    logic [31:0]      readData;

    // Address decode; a simultaneous read+write is handled purely as a write.
    always_comb begin
        aligned     = (bus.mem_addr[1:0] == 2'b00);
        ramOk       = aligned && ({1'b0, bus.mem_addr} < RAM_BYTES);
        mmioOk      = aligned && (bus.mem_addr[31:5] == 27'h400_0000)
                              && (bus.mem_addr[4:0] <= OFF_STATUS);
        regOff      = bus.mem_addr[4:0];
        ramIdx      = bus.mem_addr[RAM_AW+1:2];
        isWrite     = bus.mem_write;
        isRead      = bus.mem_read && !bus.mem_write;
        fifoFull    = (fifoCount_q == FULL_COUNT);
        fifoEmpty   = (fifoCount_q == '0);
        ramWe       = isWrite && ramOk;
        gpioWe      = isWrite && mmioOk && (regOff == OFF_GPIO);
        pushReq     = isWrite && mmioOk && (regOff == OFF_TX_DATA);
        statusClear = isWrite && mmioOk && (regOff == OFF_STATUS) && bus.mem_wdata[2];
        shadowLatch = isRead && mmioOk && (regOff == OFF_CYCLE_LO);
        pop         = !fifoEmpty && bus.tx_ready;
        pushOk      = pushReq && (!fifoFull || pop);
        overflow    = pushReq && fifoFull && !pop;
    end

    // Read mux: unmapped and misaligned addresses return zero.
    always_comb begin
        readData = '0;
        if (ramOk) begin
            readData = ram[ramIdx];
        end else if (mmioOk) begin
            case (regOff)
                OFF_CYCLE_LO: readData = cycleCount_q[31:0];
                OFF_CYCLE_HI: readData = cycleShadow_q;
                OFF_GPIO:     readData = gpio_q;
                OFF_TX_DATA:  readData = '0;
                OFF_STATUS:   readData = {24'b0, 4'(fifoCount_q), 1'b0,
                                          ovf_q, fifoEmpty, fifoFull};
                default:      readData = '0;
            endcase
        end
    end

    // Next-state for counter, shadow, GPIO and FIFO bookkeeping; an overflow
    // in the same cycle as a STATUS clear keeps ovf set.
    always_comb begin
        cycleCount_d  = cycleCount_q + 64'd1;
        cycleShadow_d = shadowLatch ? cycleCount_q[63:32] : cycleShadow_q;
        gpio_d        = gpioWe ? bus.mem_wdata : gpio_q;
        rdPtr_d       = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        wrPtr_d       = pushOk ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        fifoCount_d   = fifoCount_q + CNT_W'(pushOk) - CNT_W'(pop);
        ovf_d         = ovf_q;
        if (overflow) begin
            ovf_d = 1'b1;
        end else if (statusClear) begin
            ovf_d = 1'b0;
        end
    end

    // Resettable state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycleCount_q  <= '0;
            cycleShadow_q <= '0;
            gpio_q        <= '0;
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
            fifoCount_q   <= '0;
            ovf_q         <= 1'b0;
        end else begin
            cycleCount_q  <= cycleCount_d;
            cycleShadow_q <= cycleShadow_d;
            gpio_q        <= gpio_d;
            rdPtr_q       <= rdPtr_d;
            wrPtr_q       <= wrPtr_d;
            fifoCount_q   <= fifoCount_d;
            ovf_q         <= ovf_d;
        end
    end

    // RAM and FIFO storage keep their contents across reset; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (ramWe && !rst) begin
            ram[ramIdx] <= bus.mem_wdata;
        end
        if (pushOk && !rst) begin
            fifoMem[wrPtr_q] <= bus.mem_wdata[7:0];
        end
    end

    assign bus.mem_rdata = readData;
    assign bus.bus_err   = (bus.mem_read || bus.mem_write) && !(ramOk || mmioOk);
    assign bus.gpio_out  = gpio_q;
    assign bus.tx_valid  = !fifoEmpty;
    assign bus.tx_data   = fifoMem[rdPtr_q];
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM, MMIO registers, TX FIFO,
// cycle-counter snapshot and asynchronous reset behaviour.
module tb_data_bus_responder;
    localparam logic [31:0] CYCLE_LO = 32'h8000_0000;
    localparam logic [31:0] CYCLE_HI = 32'h8000_0004;
    localparam logic [31:0] GPIO     = 32'h8000_0008;
    localparam logic [31:0] TX_DATA  = 32'h8000_000C;
    localparam logic [31:0] STATUS   = 32'h8000_0010;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    data_bus_responder_if bus ();

    data_bus_responder #(
        .RAM_WORDS (256),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bus cycle just after the falling edge, then settle before checks.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic rdy);
        @(negedge clk);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.tx_ready  = rdy;
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Directed sequence of bus cycles with expected results worked out by hand.
    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.tx_ready  = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        applyStimulus(1, 0, STATUS, 0, 0);
        checkOutput("reset_status", bus.mem_rdata, 32'h0000_0002);
        checkOutput("reset_gpio", bus.gpio_out, 32'h0);
        checkOutput("reset_txvalid", {31'b0, bus.tx_valid}, 32'h0);
        checkOutput("reset_buserr", {31'b0, bus.bus_err}, 32'h0);

        // Release reset between edges; the counter reads 0 until the next edge
        rst          = 1'b0;
        bus.mem_addr = CYCLE_LO;
        #1;
        checkOutput("cycle_first", bus.mem_rdata, 32'd0);
        applyStimulus(1, 0, CYCLE_LO, 0, 0);
        checkOutput("cycle_n1", bus.mem_rdata, 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, CYCLE_LO, 0, 0);
        checkOutput("cycle_n4", bus.mem_rdata, 32'd4);
        applyStimulus(1, 0, CYCLE_HI, 0, 0);
        checkOutput("cycle_hi_zero", bus.mem_rdata, 32'd0);

        // RAM write/read, misalignment, read-during-write, top word, out of range
        applyStimulus(0, 1, 32'h40, 32'hDEAD_BEEF, 0);
        checkOutput("ram_wr_buserr", {31'b0, bus.bus_err}, 32'h0);
        applyStimulus(1, 0, 32'h40, 0, 0);
        checkOutput("ram_rd_40", bus.mem_rdata, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 32'h42, 0, 0);
        checkOutput("misalign_buserr", {31'b0, bus.bus_err}, 32'h1);
        checkOutput("misalign_rdata", bus.mem_rdata, 32'h0);
        applyStimulus(0, 1, 32'h44, 32'h1234_5678, 0);
        applyStimulus(1, 1, 32'h44, 32'hCAFE_F00D, 0);
        checkOutput("rdwr_prewrite", bus.mem_rdata, 32'h1234_5678);
        applyStimulus(1, 0, 32'h44, 0, 0);
        checkOutput("rdwr_after", bus.mem_rdata, 32'hCAFE_F00D);
        applyStimulus(0, 1, 32'h3FC, 32'h0BAD_F00D, 0);
        applyStimulus(1, 0, 32'h3FC, 0, 0);
        checkOutput("ram_top_word", bus.mem_rdata, 32'h0BAD_F00D);
        applyStimulus(1, 0, 32'h400, 0, 0);
        checkOutput("ram_end_buserr", {31'b0, bus.bus_err}, 32'h1);
        checkOutput("ram_end_rdata", bus.mem_rdata, 32'h0);
        applyStimulus(0, 1, 32'h41, 32'hFFFF_FFFF, 0);
        checkOutput("misalign_wr_buserr", {31'b0, bus.bus_err}, 32'h1);
        applyStimulus(1, 0, 32'h40, 0, 0);
        checkOutput("misalign_wr_ignored", bus.mem_rdata, 32'hDEAD_BEEF);

        // GPIO
        applyStimulus(0, 1, GPIO, 32'hA5A5_0001, 0);
        applyStimulus(1, 0, GPIO, 0, 0);
        checkOutput("gpio_rd", bus.mem_rdata, 32'hA5A5_0001);
        checkOutput("gpio_out", bus.gpio_out, 32'hA5A5_0001);

        // TX FIFO: fill past full with the consumer stalled
        applyStimulus(0, 1, TX_DATA, 32'h11, 0);
        applyStimulus(0, 1, TX_DATA, 32'h22, 0);
        checkOutput("tx_first_valid", {31'b0, bus.tx_valid}, 32'h1);
        checkOutput("tx_first_data", {24'b0, bus.tx_data}, 32'h11);
        applyStimulus(0, 1, TX_DATA, 32'h33, 0);
        applyStimulus(0, 1, TX_DATA, 32'h44, 0);
        applyStimulus(0, 1, TX_DATA, 32'h55, 0);
        applyStimulus(1, 0, STATUS, 0, 0);
        checkOutput("status_ovf_full", bus.mem_rdata, 32'h0000_0045);
        applyStimulus(0, 1, STATUS, 32'h4, 0);
        applyStimulus(1, 0, STATUS, 0, 0);
        checkOutput("status_ovf_clear", bus.mem_rdata, 32'h0000_0041);

        // Push while full with a simultaneous pop is accepted
        applyStimulus(0, 1, TX_DATA, 32'h66, 1);
        checkOutput("full_pushpop_head", {24'b0, bus.tx_data}, 32'h11);
        applyStimulus(1, 0, STATUS, 0, 0);
        checkOutput("full_pushpop_status", bus.mem_rdata, 32'h0000_0041);

        // Drain in order, then an idle pop on empty must not underflow
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("drain_0", {24'b0, bus.tx_data}, 32'h22);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("drain_1", {24'b0, bus.tx_data}, 32'h33);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("drain_2", {24'b0, bus.tx_data}, 32'h44);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("drain_3", {24'b0, bus.tx_data}, 32'h66);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("drain_empty_valid", {31'b0, bus.tx_valid}, 32'h0);
        applyStimulus(1, 0, STATUS, 0, 0);
        checkOutput("drain_empty_status", bus.mem_rdata, 32'h0000_0002);
        applyStimulus(1, 0, TX_DATA, 0, 0);
        checkOutput("txdata_rd_zero", bus.mem_rdata, 32'h0);
        checkOutput("txdata_rd_buserr", {31'b0, bus.bus_err}, 32'h0);

        // Unmapped addresses and read-only writes
        applyStimulus(0, 1, 32'h8000_0020, 32'hFFFF_FFFF, 0);
        checkOutput("unmapped_wr_buserr", {31'b0, bus.bus_err}, 32'h1);
        applyStimulus(1, 0, 32'h9000_0000, 0, 0);
        checkOutput("unmapped_rd_buserr", {31'b0, bus.bus_err}, 32'h1);
        checkOutput("unmapped_rd_rdata", bus.mem_rdata, 32'h0);
        applyStimulus(1, 0, GPIO, 0, 0);
        checkOutput("unmapped_no_change", bus.mem_rdata, 32'hA5A5_0001);
        applyStimulus(0, 1, CYCLE_LO, 32'h0, 0);
        checkOutput("ro_write_buserr", {31'b0, bus.bus_err}, 32'h0);

        // Asynchronous reset between edges with a byte queued
        applyStimulus(0, 1, TX_DATA, 32'h77, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pre_reset_valid", {31'b0, bus.tx_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_gpio", bus.gpio_out, 32'h0);
        checkOutput("async_rst_valid", {31'b0, bus.tx_valid}, 32'h0);
        applyStimulus(1, 0, 32'h40, 0, 0);
        checkOutput("ram_retained", bus.mem_rdata, 32'hDEAD_BEEF);
        rst = 1'b0;
        applyStimulus(1, 0, STATUS, 0, 0);
        checkOutput("post_rst_status", bus.mem_rdata, 32'h0000_0002);

        // Counter carry into the high half and the shadow snapshot
        applyStimulus(0, 0, 0, 0, 0);
        force dut.cycleCount_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycleCount_q;
        applyStimulus(1, 0, CYCLE_LO, 0, 0);
        checkOutput("carry_lo", bus.mem_rdata, 32'h0);
        applyStimulus(1, 0, CYCLE_HI, 0, 0);
        checkOutput("carry_hi", bus.mem_rdata, 32'h1);

        applyStimulus(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
